// File: rtl/corr_score_engine_if.sv
// Bundle between the search controller / pixel sources and the correlation scorer.
// Signal names match the original scorer ports so the controller can be rewired without renaming.
interface corr_score_engine_if #(
    parameter int PIX_W = 10,
    parameter int ACC_W = 32
);
    logic             iStart;
    logic             iMode;
    logic [12:0]      iXstart;
    logic [12:0]      iYstart;
    logic [12:0]      oX_sram;
    logic [12:0]      oY_sram;
    logic [12:0]      oX_search;
    logic [12:0]      oY_search;
    logic             oAddrValid;
    logic [PIX_W-1:0] iReading_sram;
    logic [PIX_W-1:0] iReading_search;
    logic             oBusy;
    logic             oDone;
    logic [ACC_W-1:0] oScore;
    logic [15:0]      oValidCount;

    modport master (
        output iStart, iMode, iXstart, iYstart, iReading_sram, iReading_search,
        input  oX_sram, oY_sram, oX_search, oY_search, oAddrValid, oBusy, oDone, oScore, oValidCount
    );

    modport slave (
        input  iStart, iMode, iXstart, iYstart, iReading_sram, iReading_search,
        output oX_sram, oY_sram, oX_search, oY_search, oAddrValid, oBusy, oDone, oScore, oValidCount
    );
endinterface

// File: rtl/corr_score_engine.sv
// Scores one WIN_W x WIN_H template window against the frame at a latched origin,
// as similarity or SAD, with out-of-frame samples excluded and a saturating accumulator.
module corr_score_engine #(
    parameter int PIX_W  = 10,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int WIN_W  = 32,
    parameter int WIN_H  = 32,
    parameter int RD_LAT = 2,
    parameter int ACC_W  = 32
) (
    input  logic iCLK,
    input  logic iRST_N,
    corr_score_engine_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t           state;
    logic [12:0]      xs, ys, xc, yc;
    logic             mode;
    logic [3:0]       drainCnt;
    logic [RD_LAT:0]  vPipe, oPipe;
    logic [ACC_W-1:0] acc;
    logic [15:0]      cnt;

    logic [13:0]      xSum, ySum;
    logic             oob;
    logic [PIX_W-1:0] diff, term;
    logic             sampleOk;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] accNext;
    logic [15:0]      cntNext;
    logic             lastX, lastY;

    always_comb begin
        // 14-bit sums so a 13-bit wrap past the frame edge still reads as out of frame
        xSum     = {1'b0, xs} + {1'b0, xc};
        ySum     = {1'b0, ys} + {1'b0, yc};
        oob      = (xSum >= 14'(H_RES)) || (ySum >= 14'(V_RES));
        diff     = (bus.iReading_sram >= bus.iReading_search) ?
                   bus.iReading_sram - bus.iReading_search :
                   bus.iReading_search - bus.iReading_sram;
        term     = mode ? diff : ~diff;
        sampleOk = vPipe[RD_LAT] && !oPipe[RD_LAT];
        sum      = {1'b0, acc} + (ACC_W+1)'(term);
        accNext  = acc;
        cntNext  = cnt;
        if (sampleOk) begin
            accNext = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            cntNext = cnt + 16'd1;
        end
        lastX    = (xc == 13'(WIN_W - 1));
        lastY    = (yc == 13'(WIN_H - 1));
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state           <= IDLE;
            xs              <= '0;
            ys              <= '0;
            xc              <= '0;
            yc              <= '0;
            mode            <= 1'b0;
            drainCnt        <= '0;
            vPipe           <= '0;
            oPipe           <= '0;
            acc             <= '0;
            cnt             <= '0;
            bus.oX_sram     <= '0;
            bus.oY_sram     <= '0;
            bus.oX_search   <= '0;
            bus.oY_search   <= '0;
            bus.oAddrValid  <= 1'b0;
            bus.oBusy       <= 1'b0;
            bus.oDone       <= 1'b0;
            bus.oScore      <= '0;
            bus.oValidCount <= '0;
        end else begin
            // Stage 0 lines up with the registered address; stage RD_LAT with its reading
            vPipe          <= {vPipe[RD_LAT-1:0], 1'b0};
            oPipe          <= {oPipe[RD_LAT-1:0], 1'b0};
            acc            <= accNext;
            cnt            <= cntNext;
            bus.oAddrValid <= 1'b0;
            bus.oDone      <= 1'b0;
            case (state)
                IDLE: begin
                    bus.oBusy <= bus.iStart;
                    if (bus.iStart) begin
                        xs    <= bus.iXstart;
                        ys    <= bus.iYstart;
                        mode  <= bus.iMode;
                        xc    <= '0;
                        yc    <= '0;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    bus.oAddrValid <= 1'b1;
                    bus.oX_sram    <= xSum[12:0];
                    bus.oY_sram    <= ySum[12:0];
                    bus.oX_search  <= xc;
                    bus.oY_search  <= yc;
                    vPipe[0]       <= 1'b1;
                    oPipe[0]       <= oob;
                    if (lastX) begin
                        xc <= '0;
                        if (lastY) begin
                            drainCnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            yc <= yc + 13'd1;
                        end
                    end else begin
                        xc <= xc + 13'd1;
                    end
                end
                DRAIN: begin
                    if (drainCnt == 4'(RD_LAT - 1)) begin
                        state <= DONE;
                    end else begin
                        drainCnt <= drainCnt + 4'd1;
                    end
                end
                DONE: begin
                    // The final reading arrives during DONE, so publish the next-state values
                    bus.oDone       <= 1'b1;
                    bus.oScore      <= accNext;
                    bus.oValidCount <= cntNext;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_score_engine.sv
// Randomized scoreboard bench for corr_score_engine: a 32-bit and a 12-bit accumulator
// instance share stimulus and a latency-modelled frame/template source.
module tb_corr_score_engine;

    localparam int PW = 10;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int WW = 4;
    localparam int WH = 2;
    localparam int RL = 2;
    localparam int NS = WW * WH;

    typedef struct { longint sum; int cnt; longint doneCyc; } exp_t;
    typedef struct { int x; int y; int xc; int yc; } addr_t;

    logic          iCLK = 1'b0;
    logic          iRST_N;
    logic          start, modeIn;
    logic [12:0]   xsIn, ysIn;
    logic [PW-1:0] pipeF [RL];
    logic [PW-1:0] pipeT [RL];
    longint        cyc = 0;
    int            nChecks = 0;
    int            nFail = 0;

    int patConst, cF, cT, pa, pb, pc, qa, qb, qc;

    exp_t  expQ[$];
    addr_t addrQ[$];

    corr_score_engine_if #(.PIX_W(PW), .ACC_W(32)) ifM();
    corr_score_engine_if #(.PIX_W(PW), .ACC_W(12)) ifS();

    corr_score_engine #(.PIX_W(PW), .H_RES(HR), .V_RES(VR), .WIN_W(WW), .WIN_H(WH),
                        .RD_LAT(RL), .ACC_W(32))
        dutM (.iCLK(iCLK), .iRST_N(iRST_N), .bus(ifM));

    corr_score_engine #(.PIX_W(PW), .H_RES(HR), .V_RES(VR), .WIN_W(WW), .WIN_H(WH),
                        .RD_LAT(RL), .ACC_W(12))
        dutS (.iCLK(iCLK), .iRST_N(iRST_N), .bus(ifS));

    assign ifM.iStart = start;
    assign ifS.iStart = start;
    assign ifM.iMode = modeIn;
    assign ifS.iMode = modeIn;
    assign ifM.iXstart = xsIn;
    assign ifS.iXstart = xsIn;
    assign ifM.iYstart = ysIn;
    assign ifS.iYstart = ysIn;
    assign ifM.iReading_sram = pipeF[RL-1];
    assign ifS.iReading_sram = pipeF[RL-1];
    assign ifM.iReading_search = pipeT[RL-1];
    assign ifS.iReading_search = pipeT[RL-1];

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic int framePix(input int x, input int y);
        if (patConst != 0) return cF;
        return (x * pa + y * pb + pc) & 1023;
    endfunction

    function automatic int tmplPix(input int x, input int y);
        if (patConst != 0) return cT;
        return (x * qa + y * qb + qc) & 1023;
    endfunction

    // Frame SRAM and template buffer: value appears RL cycles after its address, junk otherwise
    always @(posedge iCLK) begin
        int x, y, xt, yt;
        x  = int'(ifM.oX_sram);
        y  = int'(ifM.oY_sram);
        xt = int'(ifM.oX_search);
        yt = int'(ifM.oY_search);
        if (ifM.oAddrValid === 1'b1 && x < HR && y < VR) pipeF[0] <= PW'(framePix(x, y));
        else pipeF[0] <= PW'($urandom);
        if (ifM.oAddrValid === 1'b1) pipeT[0] <= PW'(tmplPix(xt, yt));
        else pipeT[0] <= PW'($urandom);
        for (int i = 1; i < RL; i++) begin
            pipeF[i] <= pipeF[i-1];
            pipeT[i] <= pipeT[i-1];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Score computed straight from the metric definition over the window
    task automatic refModel(input int xs, input int ys, input int m,
                            output longint sum, output int cnt);
        sum = 0;
        cnt = 0;
        for (int yc = 0; yc < WH; yc++) begin
            for (int xc = 0; xc < WW; xc++) begin
                int x, y, f, t, d;
                x = xs + xc;
                y = ys + yc;
                if (x < HR && y < VR) begin
                    f = framePix(x, y);
                    t = tmplPix(xc, yc);
                    d = (f > t) ? f - t : t - f;
                    sum += (m != 0) ? d : (1 << PW) - 1 - d;
                    cnt++;
                end
            end
        end
    endtask

    // Called at a negedge with the engine idle; returns at the following negedge
    task automatic startWin(input int xs, input int ys, input int m);
        exp_t e;
        refModel(xs, ys, m, e.sum, e.cnt);
        e.doneCyc = cyc + 1 + NS + RL + 1;
        expQ.push_back(e);
        for (int yc = 0; yc < WH; yc++)
            for (int xc = 0; xc < WW; xc++)
                addrQ.push_back('{(xs + xc) & 8191, (ys + yc) & 8191, xc, yc});
        start  = 1'b1;
        xsIn   = 13'(xs);
        ysIn   = 13'(ys);
        modeIn = m[0];
        @(negedge iCLK);
        start  = 1'b0;
        xsIn   = 13'($urandom);
        ysIn   = 13'($urandom);
        modeIn = 1'($urandom);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge iCLK);
        if (expQ.size() != 0) begin
            check("done_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
            addrQ.delete();
        end
    endtask

    task automatic setRandomPattern();
        patConst = ($urandom_range(0, 3) == 0) ? 1 : 0;
        cF = $urandom_range(0, 1023);
        cT = $urandom_range(0, 1023);
        pa = $urandom_range(0, 1023);
        pb = $urandom_range(0, 1023);
        pc = $urandom_range(0, 1023);
        qa = $urandom_range(0, 1023);
        qb = $urandom_range(0, 1023);
        qc = $urandom_range(0, 1023);
    endtask

    // Monitor: pops the scoreboard whenever the engine presents an address or a result
    always @(negedge iCLK) begin
        addr_t a;
        exp_t  e;
        if (iRST_N === 1'b1) begin
            if (ifM.oAddrValid !== 1'b0) begin
                if (addrQ.size() == 0) check("addr_extra", 64'(ifM.oAddrValid), 64'd0);
                else begin
                    a = addrQ.pop_front();
                    check("x_sram", 64'(ifM.oX_sram), 64'(a.x));
                    check("y_sram", 64'(ifM.oY_sram), 64'(a.y));
                    check("x_search", 64'(ifM.oX_search), 64'(a.xc));
                    check("y_search", 64'(ifM.oY_search), 64'(a.yc));
                end
            end
            if (ifM.oDone !== 1'b0 || ifS.oDone !== 1'b0) begin
                check("done_align", 64'(ifS.oDone), 64'(ifM.oDone));
                if (expQ.size() == 0) check("done_extra", 64'd1, 64'd0);
                else begin
                    e = expQ.pop_front();
                    check("score", 64'(ifM.oScore), 64'(e.sum));
                    check("score_sat12", 64'(ifS.oScore), 64'((e.sum > 4095) ? 4095 : e.sum));
                    check("valid_count", 64'(ifM.oValidCount), 64'(e.cnt));
                    check("valid_count_sat12", 64'(ifS.oValidCount), 64'(e.cnt));
                    check("done_cycle", 64'(cyc), 64'(e.doneCyc));
                    check("busy_at_done", 64'(ifM.oBusy), 64'd1);
                end
            end
        end
    end

    initial begin
        bit b2b;
        int xs, ys, m;
        iRST_N = 1'b0;
        start = 1'b0;
        modeIn = 1'b0;
        xsIn = '0;
        ysIn = '0;
        setRandomPattern();
        patConst = 1;
        cF = 500;
        cT = 500;
        repeat (3) @(negedge iCLK);
        check("rst_busy", 64'(ifM.oBusy), 64'd0);
        check("rst_done", 64'(ifM.oDone), 64'd0);
        check("rst_addr_valid", 64'(ifM.oAddrValid), 64'd0);
        check("rst_score", 64'(ifM.oScore), 64'd0);
        check("rst_valid_count", 64'(ifM.oValidCount), 64'd0);
        check("rst_addr", 64'({ifM.oX_sram, ifM.oY_sram, ifM.oX_search, ifM.oY_search}), 64'd0);
        check("rst_score_sat12", 64'(ifS.oScore), 64'd0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Directed windows: identical data, SAD / similarity, frame corner
        startWin(0, 0, 0);
        waitDrain();
        cF = 600;
        cT = 100;
        startWin(0, 0, 1);
        waitDrain();
        startWin(0, 0, 0);
        waitDrain();
        cF = 500;
        cT = 500;
        startWin(638, 479, 0);
        waitDrain();

        // A second start mid-scan must be ignored
        setRandomPattern();
        startWin(100, 50, 0);
        repeat (3) @(negedge iCLK);
        start = 1'b1;
        xsIn = 13'd300;
        ysIn = 13'd200;
        modeIn = 1'b1;
        @(negedge iCLK);
        start = 1'b0;
        waitDrain();

        // Reset while draining abandons the window
        startWin(20, 30, 1);
        repeat (NS + 1) @(negedge iCLK);
        iRST_N = 1'b0;
        expQ.delete();
        addrQ.delete();
        @(negedge iCLK);
        iRST_N = 1'b1;
        check("drain_rst_score", 64'(ifM.oScore), 64'd0);
        check("drain_rst_busy", 64'(ifM.oBusy), 64'd0);
        check("drain_rst_done", 64'(ifM.oDone), 64'd0);
        repeat (20) @(negedge iCLK);
        startWin(20, 30, 1);
        waitDrain();

        for (int n = 0; n < 40; n++) begin
            b2b = (expQ.size() != 0) && ($urandom_range(0, 1) == 1);
            if (b2b) begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge iCLK);
                    if (ifM.oDone === 1'b1) break;
                end
            end else begin
                waitDrain();
                repeat ($urandom_range(0, 3)) @(negedge iCLK);
            end
            setRandomPattern();
            case ($urandom_range(0, 3))
                0: begin xs = $urandom_range(630, 639); ys = $urandom_range(0, 479); end
                1: begin xs = $urandom_range(0, 639);   ys = $urandom_range(470, 481); end
                2: begin xs = $urandom_range(8185, 8191); ys = $urandom_range(0, 8191); end
                default: begin xs = $urandom_range(0, 700); ys = $urandom_range(0, 500); end
            endcase
            m = $urandom_range(0, 1);
            startWin(xs, ys, m);
        end
        waitDrain();
        repeat (4) @(negedge iCLK);
        check("queues_empty", 64'(expQ.size() + addrQ.size()), 64'd0);
        check("idle_busy", 64'(ifM.oBusy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
